// File: rtl/data_memory_ctrl.sv
// ============================================================================
// Module : data_memory_ctrl
// Brief  : Byte-addressed data memory with valid/ready requests, registered
//          responses, error reporting and an optional post-reset clear sweep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module data_memory_ctrl #(
    parameter int DEPTH          = 256,
    parameter int ADDR_WIDTH     = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic                  busy
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam logic [c_IDX_W-1:0] c_LAST = c_IDX_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam state_t c_RST_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;

    state_t               state_q, state_d;
    logic [c_IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic [31:0]          mem_q [DEPTH];

    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_error_q, resp_error_d;
    logic [31:0]          resp_rdata_q, resp_rdata_d;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_misalign;
    logic                 w_error;
    logic                 w_store;
    logic                 w_clear;
    logic [c_IDX_W-1:0]   w_idx;
    logic [3:0]           w_be;
    logic [31:0]          w_wdata;
    logic [31:0]          w_word;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load;

    assign w_idx = req_addr[c_IDX_W+1:2];

    // Every address bit above the word index must be zero: no aliasing.
    generate
        if (ADDR_WIDTH > c_IDX_W + 2) begin : g_upper_chk
            assign w_in_range = ~|req_addr[ADDR_WIDTH-1:c_IDX_W+2];
        end else begin : g_no_upper
            assign w_in_range = 1'b1;
        end
    endgenerate

    always_comb begin
        w_misalign = 1'b0;
        case (req_size)
            2'b01:   w_misalign = req_addr[0];
            2'b10:   w_misalign = |req_addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end

    assign w_error  = (req_size == 2'b11) | w_misalign | ~w_in_range;
    assign w_ready  = (state_q == ST_IDLE) & ~reset;
    assign w_accept = req_valid & w_ready;
    assign w_store  = w_accept & req_write & ~w_error;
    assign w_clear  = (state_q == ST_INIT) & ~reset;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_size)
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    assign w_word = mem_q[w_idx];

    always_comb begin
        w_byte = w_word[{req_addr[1:0], 3'b000} +: 8];
        w_half = req_addr[1] ? w_word[31:16] : w_word[15:0];
        case (req_size)
            2'b00:   w_load = {{24{~req_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{~req_unsigned & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_clear) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (w_store) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    mem_q[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        resp_valid_d = w_accept;
        resp_error_d = w_accept & w_error;
        resp_rdata_d = '0;
        if (w_accept && !req_write && !w_error) begin
            resp_rdata_d = w_load;
        end
        case (state_q)
            ST_INIT: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == c_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= c_RST_STATE;
            clr_cnt_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_error_q <= resp_error_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Masking with reset drops a response whose cycle coincides with a reset request.
    assign resp_valid = resp_valid_q & ~reset;
    assign resp_error = resp_error_q & ~reset;
    assign resp_rdata = reset ? 32'd0 : resp_rdata_q;
    assign req_ready  = w_ready;
    assign busy       = (state_q == ST_INIT);

endmodule

`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
// ============================================================================
// Module : tb_data_memory_ctrl
// Brief  : Scoreboard bench for data_memory_ctrl with a byte-array reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_data_memory_ctrl;

    localparam int DEPTH = 256;
    localparam int AW    = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        busy;

    data_memory_ctrl #(
        .DEPTH          (DEPTH),
        .ADDR_WIDTH     (AW),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rd;
        logic        er;
    } exp_t;

    exp_t        sb_q[$];
    logic [7:0]  ref_mem [DEPTH*4];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic ref_clear();
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    endtask

    // Little-endian byte array model: error rules, lane update, extension by arithmetic.
    task automatic model(input bit w, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit er);
        int     n;
        longint v;
        n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'(DEPTH * 4));
        rd = 32'd0;
        if (!er) begin
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v | (longint'(ref_mem[int'(a) + i]) << (8 * i));
                if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
                rd = v[31:0];
            end
        end
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit push, input bit use_x,
                         input logic [31:0] xrd, input bit xer);
        logic [31:0] rd;
        bit          er;
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        model(w, sz, uns, a, wd, rd, er);
        if (use_x) begin
            rd = xrd;
            er = xer;
        end
        if (push) sb_q.push_back('{rd: rd, er: er});
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic op(input bit w, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd);
        issue(w, sz, uns, a, wd, 1'b1, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic op_x(input bit w, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] xrd, input bit xer);
        issue(w, sz, uns, a, wd, 1'b1, 1'b1, xrd, xer);
    endtask

    // Counts busy cycles from the next negedge; flags any req_ready seen while busy.
    task automatic sweep_len(output int n, input int stop);
        int rdy_seen;
        n        = 0;
        rdy_seen = 0;
        @(negedge clock);
        while (busy && n < stop) begin
            n++;
            if (req_ready) rdy_seen++;
            @(negedge clock);
        end
        chk("ready_low_while_busy", 32'(rdy_seen), 32'd0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%h err=%b want no response",
                         resp_rdata, resp_error);
            end else begin
                e = sb_q.pop_front();
                total++;
                if (resp_rdata !== e.rd || resp_error !== e.er) begin
                    bad++;
                    $display("FAIL resp: got rdata=%h err=%b want rdata=%h err=%b",
                             resp_rdata, resp_error, e.rd, e.er);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          r;
        int          sz_n;
        bit          w;
        logic [1:0]  sz;
        logic [31:0] a;

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        ref_clear();

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", {31'd0, resp_error}, 32'd0);
        chk("rst_req_ready",  {31'd0, req_ready}, 32'd0);
        chk("rst_busy",       {31'd0, busy}, 32'd1);

        // Hold a store during the sweep; it must be ignored.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h3FC;
        req_wdata = 32'hFFFF_FFFF;
        @(posedge clock);
        #1 reset = 1'b0;
        sweep_len(n, 1000);
        req_valid = 1'b0;
        chk("sweep_len_initial", 32'(n), 32'd256);

        // Test 1
        op_x(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0000_0000, 1'b0);

        // Test 2
        op(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB);
        op_x(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0);
        op_x(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h0000_00AA, 1'b0);
        op_x(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF_8899, 1'b0);

        // Test 3
        op_x(1'b1, 2'b10, 1'b0, 32'h20, 32'h1122_3344, 32'h0, 1'b0);
        chk("store_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("store_resp_rdata", resp_rdata, 32'd0);
        op_x(1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FF55, 32'h0, 1'b0);
        op_x(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1155_3344, 1'b0);

        // Test 4
        op_x(1'b1, 2'b01, 1'b0, 32'h21, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op_x(1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op_x(1'b1, 2'b11, 1'b0, 32'h20, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op_x(1'b1, 2'b10, 1'b0, 32'h400, 32'hFFFF_FFFF, 32'h0, 1'b1);
        op_x(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1);
        op_x(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1155_3344, 1'b0);

        // Test 5: back-to-back store then load
        op_x(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("b2b_first_valid", {31'd0, resp_valid}, 32'd1);
        op_x(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 1'b0);
        chk("b2b_second_valid", {31'd0, resp_valid}, 32'd1);
        chk("b2b_second_rdata", resp_rdata, 32'hDEAD_BEEF);

        // Randomised traffic, mostly back-to-back
        for (int k = 0; k < 300; k++) begin
            r    = int'($urandom_range(0, 19));
            sz   = (r < 6) ? 2'd0 : (r < 12) ? 2'd1 : (r < 19) ? 2'd2 : 2'd3;
            sz_n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            w    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 63));
            else                           a = 32'($urandom_range(0, DEPTH * 4 - 1));
            if ($urandom_range(0, 9) != 0) a = a & ~32'(sz_n - 1);
            if ($urandom_range(0, 19) == 0) a = $urandom | 32'h400;
            op(w, sz, 1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clock);
                #1;
            end
        end

        // Test 6: reset right after a load is accepted drops its response
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        chk("drop_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        sweep_len(n, 1000);
        chk("sweep_len_after_drop", 32'(n), 32'd256);
        ref_clear();
        op_x(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);
        op_x(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

        // Reset in the middle of INIT restarts the sweep from zero
        op(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFE_F00D);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        sweep_len(n, 100);
        chk("partial_sweep", 32'(n), 32'd100);
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        sweep_len(n, 1000);
        chk("sweep_len_mid_init", 32'(n), 32'd256);
        ref_clear();
        op_x(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 32'h0, 1'b0);

        repeat (4) @(posedge clock);
        @(negedge clock);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
